// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer in front of the UART transmitter: circular FIFO plus a
// two-state controller that issues one enable pulse per byte and waits for done.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  tx_en,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_done,
    output logic                  tx_busy
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q;
    logic                  tx_en_q, tx_en_d;
    logic                  tx_busy_q, tx_busy_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  wr_accept;
    logic                  pop;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign wr_accept = wr_en && !full;

    // Storage carries no reset; contents are only read once written.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_en_d   = 1'b0;
        tx_busy_d = tx_busy_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    tx_data_d = mem[rd_ptr_q];
                    tx_en_d   = 1'b1;
                    tx_busy_d = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (tx_done) begin
                    tx_busy_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A same-cycle write and pop leave the occupancy unchanged.
    always_comb begin
        count_d = count_q;
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_en_q    <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tx_en_q   <= tx_en_d;
            tx_busy_q <= tx_busy_d;
            tx_data_q <= tx_data_d;
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
            end
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_en    = tx_en_q;
    assign tx_busy  = tx_busy_q;
    assign tx_data  = tx_data_q;

endmodule
